// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display scheduler and its helpers.
// Also provides a counter-width helper that never returns a zero width.
package display_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } sched_state_t;

    localparam logic [7:0]  SEG_OFF   = 8'hFF;
    localparam logic [7:0]  AN_OFF    = 8'hFF;
    localparam logic [15:0] LIGHT_OFF = 16'h0;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Display bus between the producers, the scheduler and the board outputs.
// master = scheduler side, slave = board/producer side.
interface display_scheduler_if #(
    parameter int N_SRC = 3
);
    import display_sched_pkg::*;

    localparam int SW = cnt_w(N_SRC);

    logic [N_SRC-1:0]    src_req;
    logic [16*N_SRC-1:0] src_light;
    logic [8*N_SRC-1:0]  src_seg;
    logic [8*N_SRC-1:0]  src_an;
    logic [15:0]         light;
    logic [7:0]          seg;
    logic [7:0]          an;
    logic [N_SRC-1:0]    grant;
    logic [SW-1:0]       cur_src;

    modport master (
        input  src_req, src_light, src_seg, src_an,
        output light, seg, an, grant, cur_src
    );

    modport slave (
        output src_req, src_light, src_seg, src_an,
        input  light, seg, an, grant, cur_src
    );

endinterface

// File: rtl/key_pulse_debounce.sv
// Raw push-button to single-cycle pulse: 2-FF synchroniser, stable-high counter,
// one pulse per press. A key held across reset must be released before it can fire.
module key_pulse_debounce
    import display_sched_pkg::*;
#(
    parameter int DEB_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_pulse
);

    localparam int              CW       = cnt_w(DEB_CYC);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          armed_reg;
    logic          pulse_reg;
    logic [CW-1:0] cnt_reg;

    // Synchroniser resets to "pressed" so a held key cannot arm itself after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            armed_reg <= 1'b0;
            pulse_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
            pulse_reg <= 1'b0;
            if (!sync2_reg) begin
                cnt_reg   <= '0;
                armed_reg <= 1'b1;
            end else if (armed_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    pulse_reg <= 1'b1;
                    armed_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign key_pulse = pulse_reg;

endmodule

// File: rtl/display_scheduler.sv
// Shares LEDs and 7-seg display among N_SRC producers: key/auto round-robin,
// alarm preemption, and a blanking gap on every source switch.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int N_SRC     = 3,
    parameter int ALARM_SRC = 0,
    parameter int DWELL_CYC = 300_000_000,
    parameter int DEB_CYC   = 2_000_000,
    parameter int BLANK_CYC = 100_000
) (
    input  logic fpga_clk,
    input  logic RST,
    input  logic key_next,
    input  logic auto_en,
    input  logic alarm_req,
    display_scheduler_if.master bus
);

    localparam int SW = cnt_w(N_SRC);
    localparam int DW = cnt_w(DWELL_CYC);
    localparam int BW = cnt_w(BLANK_CYC);

    localparam logic [SW-1:0] ALARM_IDX  = SW'(ALARM_SRC);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

    logic key_pulse;

    key_pulse_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key (
        .clk       (fpga_clk),
        .rst_n     (RST),
        .key_raw   (key_next),
        .key_pulse (key_pulse)
    );

    logic [15:0] light_arr [N_SRC];
    logic [7:0]  seg_arr   [N_SRC];
    logic [7:0]  an_arr    [N_SRC];

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign light_arr[gi] = bus.src_light[16*gi +: 16];
            assign seg_arr[gi]   = bus.src_seg[8*gi +: 8];
            assign an_arr[gi]    = bus.src_an[8*gi +: 8];
        end
    endgenerate

    sched_state_t  state_reg, state_next;
    logic [SW-1:0] cur_reg, cur_next;
    logic [BW-1:0] blank_cnt_reg, blank_cnt_next;
    logic [DW-1:0] dwell_reg, dwell_next;

    logic [15:0]      light_reg;
    logic [7:0]       seg_reg;
    logic [7:0]       an_reg;
    logic [N_SRC-1:0] grant_reg;

    logic [SW-1:0] rr_next;
    logic [SW-1:0] lowest_req;
    logic          any_req;
    logic          alarm_hit;

    // Next requester after cur_reg; scanning from the far end lets the nearest win.
    // A full lap (k = N_SRC) lands on cur_reg itself, covering the sole-requester case.
    always_comb begin : rr_finder
        logic [SW:0] pos;
        rr_next = cur_reg;
        pos     = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            pos = {1'b0, cur_reg} + (SW+1)'(k);
            if (pos >= (SW+1)'(N_SRC)) begin
                pos = pos - (SW+1)'(N_SRC);
            end
            if (bus.src_req[pos[SW-1:0]]) begin
                rr_next = pos[SW-1:0];
            end
        end
    end

    always_comb begin
        lowest_req = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (bus.src_req[k]) begin
                lowest_req = SW'(k);
            end
        end
    end

    assign any_req   = |bus.src_req;
    assign alarm_hit = alarm_req & bus.src_req[ALARM_SRC];

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        blank_cnt_next = blank_cnt_reg;
        dwell_next     = dwell_reg;
        case (state_reg)
            IDLE: begin
                blank_cnt_next = '0;
                dwell_next     = '0;
                if (any_req) begin
                    cur_next   = alarm_hit ? ALARM_IDX : lowest_req;
                    state_next = BLANK;
                end
            end
            BLANK: begin
                // cur_reg already holds the target; it may have dropped meanwhile.
                if (blank_cnt_reg == BLANK_LAST) begin
                    blank_cnt_next = '0;
                    dwell_next     = '0;
                    if (bus.src_req[cur_reg]) begin
                        state_next = SHOW;
                    end else if (any_req) begin
                        cur_next   = rr_next;
                        state_next = SHOW;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    blank_cnt_next = blank_cnt_reg + 1'b1;
                end
            end
            SHOW: begin
                if (alarm_hit && (cur_reg != ALARM_IDX)) begin
                    cur_next   = ALARM_IDX;
                    state_next = BLANK;
                    dwell_next = '0;
                end else if (!bus.src_req[cur_reg]) begin
                    dwell_next = '0;
                    if (any_req) begin
                        cur_next   = rr_next;
                        state_next = BLANK;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (alarm_req && (cur_reg == ALARM_IDX)) begin
                    dwell_next = '0;
                end else if (key_pulse || (auto_en && (dwell_reg == DWELL_LAST))) begin
                    dwell_next = '0;
                    if (rr_next != cur_reg) begin
                        cur_next   = rr_next;
                        state_next = BLANK;
                    end
                end else begin
                    dwell_next = auto_en ? dwell_reg + 1'b1 : '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so grant and data change together.
    always_ff @(posedge fpga_clk or negedge RST) begin
        if (!RST) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            blank_cnt_reg <= '0;
            dwell_reg     <= '0;
            light_reg     <= LIGHT_OFF;
            seg_reg       <= SEG_OFF;
            an_reg        <= AN_OFF;
            grant_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            blank_cnt_reg <= blank_cnt_next;
            dwell_reg     <= dwell_next;
            if (state_next == SHOW) begin
                light_reg <= light_arr[cur_next];
                seg_reg   <= seg_arr[cur_next];
                an_reg    <= an_arr[cur_next];
                grant_reg <= {{(N_SRC-1){1'b0}}, 1'b1} << cur_next;
            end else begin
                light_reg <= LIGHT_OFF;
                seg_reg   <= SEG_OFF;
                an_reg    <= AN_OFF;
                grant_reg <= '0;
            end
        end
    end

    assign bus.light   = light_reg;
    assign bus.seg     = seg_reg;
    assign bus.an      = an_reg;
    assign bus.grant   = grant_reg;
    assign bus.cur_src = cur_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a behavioural model compared every cycle
// and literal checkpoints for each scenario.
module tb_display_scheduler;

    localparam int N     = 3;
    localparam int ALARM = 0;
    localparam int DWELL = 50;
    localparam int DEB   = 4;
    localparam int BLANK = 3;

    logic fpga_clk;
    logic RST;
    logic key_next;
    logic auto_en;
    logic alarm_req;

    display_scheduler_if #(.N_SRC(N)) bus ();

    display_scheduler #(
        .N_SRC     (N),
        .ALARM_SRC (ALARM),
        .DWELL_CYC (DWELL),
        .DEB_CYC   (DEB),
        .BLANK_CYC (BLANK)
    ) dut (
        .fpga_clk  (fpga_clk),
        .RST       (RST),
        .key_next  (key_next),
        .auto_en   (auto_en),
        .alarm_req (alarm_req),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Key history: bit j is the raw key sampled j edges ago (1 while in reset).
    logic [15:0] khist;
    bit          m_show;
    int          m_blank_left;
    int          m_cur;
    int          m_dwell;
    logic [15:0] exp_light;
    logic [7:0]  exp_seg;
    logic [7:0]  exp_an;
    logic [2:0]  exp_grant;

    function automatic int rr_from(input int base, input logic [2:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic int lowest(input logic [2:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [2:0] req;
        bit pulse;
        bit any;
        int nrr;
        if (!RST) begin
            khist        = '1;
            m_show       = 0;
            m_blank_left = 0;
            m_cur        = 0;
            m_dwell      = 0;
        end else begin
            khist = {khist[14:0], key_next};
            // Pulse reaches the scheduler once the key was high for DEB samples
            // after a low, delayed by two sync stages plus the pulse register.
            pulse = 1;
            for (int j = 3; j <= DEB + 2; j++) if (!khist[j]) pulse = 0;
            if (khist[DEB + 3]) pulse = 0;
            req = bus.src_req;
            any = |req;
            nrr = rr_from(m_cur, req);
            if (m_show) begin
                if (alarm_req && req[ALARM] && m_cur != ALARM) begin
                    m_show = 0; m_cur = ALARM; m_blank_left = BLANK;
                end else if (!req[m_cur]) begin
                    m_show = 0;
                    if (any) begin m_cur = nrr; m_blank_left = BLANK; end
                end else if (alarm_req && m_cur == ALARM) begin
                    m_dwell = 0;
                end else if (pulse || (auto_en && m_dwell + 1 == DWELL)) begin
                    m_dwell = 0;
                    if (nrr != m_cur) begin m_show = 0; m_cur = nrr; m_blank_left = BLANK; end
                end else begin
                    m_dwell = auto_en ? m_dwell + 1 : 0;
                end
            end else if (m_blank_left > 0) begin
                m_blank_left--;
                if (m_blank_left == 0) begin
                    m_dwell = 0;
                    if (req[m_cur]) m_show = 1;
                    else if (any) begin m_cur = nrr; m_show = 1; end
                end
            end else if (any) begin
                m_cur        = (alarm_req && req[ALARM]) ? ALARM : lowest(req);
                m_blank_left = BLANK;
            end
        end
        if (m_show) begin
            exp_light = bus.src_light[16*m_cur +: 16];
            exp_seg   = bus.src_seg[8*m_cur +: 8];
            exp_an    = bus.src_an[8*m_cur +: 8];
            exp_grant = 3'b001 << m_cur;
        end else begin
            exp_light = 16'h0;
            exp_seg   = 8'hFF;
            exp_an    = 8'hFF;
            exp_grant = 3'b000;
        end
    endtask

    always @(posedge fpga_clk) begin
        model_step();
        #1;
        check("grant",   32'(bus.grant),   32'(exp_grant));
        check("cur_src", 32'(bus.cur_src), 32'(m_cur));
        check("light",   32'(bus.light),   32'(exp_light));
        check("seg",     32'(bus.seg),     32'(exp_seg));
        check("an",      32'(bus.an),      32'(exp_an));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic press(input int hold);
        key_next = 1'b1;
        tick(hold);
        key_next = 1'b0;
        tick(12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST           = 1'b0;
        key_next      = 1'b0;
        auto_en       = 1'b0;
        alarm_req     = 1'b0;
        bus.src_req   = 3'b000;
        bus.src_light = {16'hC333, 16'hB222, 16'hA111};
        bus.src_seg   = {8'h33, 8'h22, 8'h11};
        bus.src_an    = {8'hFB, 8'hFD, 8'hFE};
        tick(2);

        // Reset mid-BLANK, then release with 3'b110
        RST = 1'b1; bus.src_req = 3'b111;
        tick(1);
        RST = 1'b0;
        @(posedge fpga_clk); #1;
        check("rst_seg",   32'(bus.seg),   32'hFF);
        check("rst_an",    32'(bus.an),    32'hFF);
        check("rst_light", 32'(bus.light), 32'h0);
        check("rst_grant", 32'(bus.grant), 32'h0);
        @(negedge fpga_clk);
        bus.src_req = 3'b110; RST = 1'b1;
        tick(3);
        check("blank_grant", 32'(bus.grant), 32'h0);
        tick(1);
        check("show1_grant", 32'(bus.grant), 32'b010);
        check("show1_cur",   32'(bus.cur_src), 32'd1);

        // Round-robin on key, wrap, and a short glitch
        bus.src_req = 3'b111;
        press(4);
        check("rr_grant2", 32'(bus.grant), 32'b100);
        press(4);
        check("rr_wrap", 32'(bus.grant), 32'b001);
        press(3);
        check("glitch_grant", 32'(bus.grant), 32'b001);
        check("glitch_cur",   32'(bus.cur_src), 32'd0);

        // Auto-rotate, then key pulse coinciding with dwell expiry
        auto_en = 1'b1;
        tick(50);
        check("auto_blank", 32'(bus.grant), 32'h0);
        check("auto_cur",   32'(bus.cur_src), 32'd1);
        tick(3);
        check("auto_show", 32'(bus.grant), 32'b010);
        tick(43);
        key_next = 1'b1; tick(4); key_next = 1'b0;
        tick(3);
        check("coinc_cur", 32'(bus.cur_src), 32'd2);
        tick(3);
        check("coinc_grant", 32'(bus.grant), 32'b100);

        // Alarm preemption; key and dwell ignored while held
        alarm_req = 1'b1;
        tick(4);
        check("alarm_grant", 32'(bus.grant), 32'b001);
        press(4);
        check("alarm_key", 32'(bus.grant), 32'b001);
        tick(60);
        check("alarm_dwell", 32'(bus.grant), 32'b001);
        alarm_req = 1'b0; auto_en = 1'b0;
        press(4);
        check("alarm_resume", 32'(bus.cur_src), 32'd1);
        check("alarm_resume_grant", 32'(bus.grant), 32'b010);

        // All requests drop -> IDLE; sole requester ignores key
        bus.src_req = 3'b000;
        tick(1);
        check("idle_grant", 32'(bus.grant), 32'h0);
        check("idle_seg",   32'(bus.seg),   32'hFF);
        tick(2);
        bus.src_req = 3'b100;
        tick(4);
        check("sole_grant", 32'(bus.grant), 32'b100);
        press(4);
        check("sole_key", 32'(bus.grant), 32'b100);

        // Data path latency
        check("seg_before", 32'(bus.seg), 32'h33);
        bus.src_seg[23:16] = 8'hC0;
        @(posedge fpga_clk); #1;
        check("seg_after", 32'(bus.seg), 32'hC0);
        @(negedge fpga_clk);

        // Target drops during BLANK -> next_rr from target
        bus.src_req = 3'b111;
        tick(2);
        key_next = 1'b1; tick(4); key_next = 1'b0;
        tick(3);
        bus.src_req = 3'b110;
        tick(4);
        check("drop_blank_cur", 32'(bus.cur_src), 32'd1);

        // Reset mid-debounce with key held: no pulse after release
        bus.src_req = 3'b111;
        key_next = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
        tick(10);
        check("deb_rst_cur",   32'(bus.cur_src), 32'd0);
        check("deb_rst_grant", 32'(bus.grant),   32'b001);
        key_next = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
